hue_div: RTL and testbench
==========================

HUE_DIV -- requirements
Module: hue_div

Interface
REQ-001: clk  input  1  single clock; all state changes on the rising edge.
REQ-002: rst_n  input  1  asynchronous active-low reset.
REQ-003: in_valid  input  1  upstream operand set is valid.
REQ-004: in_ready  output  1  block can accept an operand set.
REQ-005: R_Gx43, G_Bx43, B_Rx43  input  32 each  IEEE-754 single-precision numerators from the upstream stage.
REQ-006: diff  input  32  IEEE-754 divisor (Max - Min).
REQ-007: Max_R, Max_G, Max_B  input  1 each  max-channel flags.
REQ-008: Max12  input  32  Max value, passed through.
REQ-009: out_valid  output  1  result valid.
REQ-010: out_ready  input  1  downstream accepts the result.
REQ-011: quot  output  32  IEEE-754 quotient.
REQ-012: sector  output  2  hue sector: 0 = R max, 1 = G max, 2 = B max, 3 = no flag set.
REQ-013: Max_out  output  32  registered Max12.
REQ-014: div_zero  output  1  set when diff is zero or denormal.

Function
REQ-015: The FSM SHALL have the states IDLE, DIV and DONE; in_ready = 1 only in IDLE with rst_n high.
REQ-016: Accept occurs when in_valid && in_ready; all inputs SHALL be latched on that edge.
REQ-017: Numerator select, by priority: Max_R -> G_Bx43, sector 0; else Max_G -> B_Rx43, sector 1; else Max_B -> R_Gx43, sector 2; else sector 3.
REQ-018: Special cases go from IDLE straight to DONE, so out_valid is high 1 cycle after accept:
  - sector 3 -> quot = 0.
  - diff exponent 0 -> quot = 0, div_zero = 1.
  - numerator exponent 0 -> quot = +/-0 with the numerator sign.
  - numerator or diff exponent 255 -> quot = sign | 0x7F800000.
REQ-019: Normal case setup:
  - sign = numerator[31] XOR diff[31].
  - e = eN - eD + 127, held as 10-bit signed.
  - mN, mD = 24-bit mantissas with the hidden 1.
REQ-020: DIV SHALL run an unsigned restoring division, one quotient bit per cycle, for exactly 26 cycles, with a 5-bit counter running 0..25.
  - Result: Q = floor(mN * 2^25 / mD).
REQ-021: Normalization and rounding:
  - Q[25] = 1 -> fraction = Q[24:2], exponent = e.
  - Otherwise -> fraction = Q[23:1], exponent = e - 1.
  - Rounding is truncation only.
REQ-022: Exponent range after normalization:
  - Final exponent >= 255 -> quot = sign | 0x7F800000.
  - Final exponent <= 0 -> quot = sign | 0.
REQ-023: Normal-case latency: out_valid rises 27 cycles after the accept edge.
REQ-024: In DONE, out_valid = 1, and quot, sector, Max_out and div_zero SHALL stay stable until out_ready = 1.
  - On out_valid && out_ready the FSM returns to IDLE.
  - out_valid drops the next cycle.
  - The next accept can happen no earlier than 1 cycle after the handshake.
REQ-025: in_valid asserted outside IDLE SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-026: div_zero SHALL be cleared on every accept and valid only while out_valid = 1.

Reset
REQ-027: rst_n low SHALL force, immediately:
  - FSM state IDLE and counter 0.
  - out_valid 0, in_ready 0.
  - quot, Max_out 0; sector 0; div_zero 0.
REQ-028: Reset asserted mid-DIV or mid-DONE SHALL abandon the operation; no out_valid follows reset release without a new accept.
REQ-029: in_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-030: Basic divide: Max_R = 1, G_Bx43 = 0x42AC0000 (86.0), diff = 0x40000000 (2.0) -> quot = 0x422C0000, sector 0, out_valid 27 cycles after accept.
REQ-031: Quotient below 1: Max_G = 1, B_Rx43 = 0x422C0000 (43.0), diff = 0x42AC0000 (86.0) -> quot = 0x3F000000, sector 1. Also numerator 0x3F800000 (1.0), diff 0x40400000 (3.0) -> quot = 0x3EAAAAAA (truncated).
REQ-032: Divide by zero: Max_B = 1, diff = 0x00000000 -> quot = 0, div_zero = 1, sector 2, out_valid 1 cycle after accept. No flag set -> sector 3, quot = 0.
REQ-033: Priority and pass-through: Max_R = Max_G = 1 -> G_Bx43 used, sector 0; Max12 = 0x437F0000 -> Max_out = 0x437F0000.
REQ-034: Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, a new in_valid is ignored; out_ready = 1 -> IDLE next cycle, then a fresh accept succeeds.
REQ-035: Reset mid-DIV: assert rst_n low at DIV cycle 10 -> all outputs 0 at once; after release in_ready = 1 and no out_valid without a new accept.

Source files
------------

// File: rtl/hue_div.sv
// Hue divider: selects the max-channel numerator, divides it by (Max - Min) with a
// 26-step restoring mantissa divider, and truncates to an IEEE-754 single result.
module hue_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] R_Gx43,
    input  logic [31:0] G_Bx43,
    input  logic [31:0] B_Rx43,
    input  logic [31:0] diff,
    input  logic        Max_R,
    input  logic        Max_G,
    input  logic        Max_B,
    input  logic [31:0] Max12,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [1:0]  sector,
    output logic [31:0] Max_out,
    output logic        div_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd25;
    localparam logic [7:0] EXP_MAX   = 8'hFF;

    state_t             state_r;
    logic [4:0]         cnt_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mant_d_r;
    logic [24:0]        rem_r;
    logic [25:0]        q_r;
    logic               pack_r;

    logic [31:0]        num_s;
    logic [1:0]         sector_s;
    logic               sign_s;
    logic signed [9:0]  exp_init_s;
    logic               spec_s;
    logic [31:0]        spec_quot_s;
    logic               spec_dz_s;
    logic               bit_s;
    logic [24:0]        rem_next_s;
    logic signed [9:0]  exp_norm_s;
    logic [22:0]        frac_s;
    logic [31:0]        packed_s;

    // Max-channel priority picks the numerator and the hue sector
    always_comb begin
        num_s    = 32'd0;
        sector_s = 2'd3;
        if (Max_R) begin
            num_s    = G_Bx43;
            sector_s = 2'd0;
        end else if (Max_G) begin
            num_s    = B_Rx43;
            sector_s = 2'd1;
        end else if (Max_B) begin
            num_s    = R_Gx43;
            sector_s = 2'd2;
        end else begin
            num_s    = 32'd0;
            sector_s = 2'd3;
        end
    end

    assign sign_s     = num_s[31] ^ diff[31];
    assign exp_init_s = $signed({2'b00, num_s[30:23]}) - $signed({2'b00, diff[30:23]}) + 10'sd127;

    // Operand classes that bypass the divider and finish in one cycle
    always_comb begin
        spec_s      = 1'b0;
        spec_quot_s = 32'd0;
        spec_dz_s   = 1'b0;
        if (sector_s == 2'd3) begin
            spec_s = 1'b1;
        end else if (diff[30:23] == 8'd0) begin
            spec_s    = 1'b1;
            spec_dz_s = 1'b1;
        end else if (num_s[30:23] == 8'd0) begin
            spec_s      = 1'b1;
            spec_quot_s = {num_s[31], 31'd0};
        end else if ((num_s[30:23] == EXP_MAX) || (diff[30:23] == EXP_MAX)) begin
            spec_s      = 1'b1;
            spec_quot_s = {sign_s, EXP_MAX, 23'd0};
        end else begin
            spec_s = 1'b0;
        end
    end

    // One restoring step: the remainder always stays below twice the divisor
    assign bit_s = (rem_r >= {1'b0, mant_d_r});

    // Conditional subtract of the divisor from the partial remainder
    always_comb begin
        if (bit_s) begin
            rem_next_s = rem_r - {1'b0, mant_d_r};
        end else begin
            rem_next_s = rem_r;
        end
    end

    // Normalize the 26-bit quotient and clamp the exponent range (truncating)
    always_comb begin
        exp_norm_s = exp_r;
        frac_s     = q_r[24:2];
        packed_s   = 32'd0;
        if (q_r[25]) begin
            exp_norm_s = exp_r;
            frac_s     = q_r[24:2];
        end else begin
            exp_norm_s = exp_r - 10'sd1;
            frac_s     = q_r[23:1];
        end
        if (exp_norm_s >= 10'sd255) begin
            packed_s = {sign_r, EXP_MAX, 23'd0};
        end else if (exp_norm_s <= 10'sd0) begin
            packed_s = {sign_r, 31'd0};
        end else begin
            packed_s = {sign_r, exp_norm_s[7:0], frac_s};
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            sign_r    <= 1'b0;
            exp_r     <= 10'sd0;
            mant_d_r  <= 24'd0;
            rem_r     <= 25'd0;
            q_r       <= 26'd0;
            pack_r    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quot      <= 32'd0;
            sector    <= 2'd0;
            Max_out   <= 32'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sector   <= sector_s;
                        Max_out  <= Max12;
                        sign_r   <= sign_s;
                        exp_r    <= exp_init_s;
                        mant_d_r <= {1'b1, diff[22:0]};
                        rem_r    <= {2'b01, num_s[22:0]};
                        q_r      <= 26'd0;
                        cnt_r    <= 5'd0;
                        if (spec_s) begin
                            quot     <= spec_quot_s;
                            div_zero <= spec_dz_s;
                            pack_r   <= 1'b0;
                            state_r  <= DONE;
                        end else begin
                            div_zero <= 1'b0;
                            pack_r   <= 1'b1;
                            state_r  <= DIV;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DIV: begin
                    rem_r <= rem_next_s << 5'd1;
                    q_r   <= {q_r[24:0], bit_s};
                    if (cnt_r == LAST_STEP) begin
                        cnt_r   <= 5'd0;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        pack_r    <= 1'b0;
                        if (pack_r) begin
                            quot <= packed_s;
                        end else begin
                            quot <= quot;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 5'd0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hue_div.sv
// Scoreboard bench for hue_div: stimulus pushes expected results, a negedge monitor
// pops and compares them whenever a new out_valid appears.
module tb_hue_div;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] R_Gx43    = 32'd0;
    logic [31:0] G_Bx43    = 32'd0;
    logic [31:0] B_Rx43    = 32'd0;
    logic [31:0] diff      = 32'd0;
    logic        Max_R     = 1'b0;
    logic        Max_G     = 1'b0;
    logic        Max_B     = 1'b0;
    logic [31:0] Max12     = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quot;
    logic [1:0]  sector;
    logic [31:0] Max_out;
    logic        div_zero;

    hue_div dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .R_Gx43(R_Gx43), .G_Bx43(G_Bx43), .B_Rx43(B_Rx43), .diff(diff),
        .Max_R(Max_R), .Max_G(Max_G), .Max_B(Max_B), .Max12(Max12),
        .out_valid(out_valid), .out_ready(out_ready), .quot(quot),
        .sector(sector), .Max_out(Max_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr, mg, mb;
        logic [31:0] rg, gb, br, dv, mx;
        logic [31:0] q;
        logic [1:0]  sec;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [1:0]  sec;
        logic [31:0] mx;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic mr, input logic mg, input logic mb,
                                input logic [31:0] rg, input logic [31:0] gb,
                                input logic [31:0] br, input logic [31:0] dv,
                                input logic [31:0] mx, input logic [31:0] q,
                                input logic [1:0] sec, input logic dz, input int lat);
        vec_t v;
        v.mr = mr; v.mg = mg; v.mb = mb;
        v.rg = rg; v.gb = gb; v.br = br; v.dv = dv; v.mx = mx;
        v.q = q; v.sec = sec; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitor: compare each newly presented result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got out_valid=1 at cycle %0d, want none pending", cyc);
            end else begin
                e = sb.pop_front();
                chk("quot", quot, e.q);
                chk("sector", {30'd0, sector}, {30'd0, e.sec});
                chk("max_out", Max_out, e.mx);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        ov_prev = out_valid;
    end

    task automatic send(input vec_t v, input bit push);
        exp_t e;
        int   tries;
        @(negedge clk);
        Max_R = v.mr; Max_G = v.mg; Max_B = v.mb;
        R_Gx43 = v.rg; G_Bx43 = v.gb; B_Rx43 = v.br; diff = v.dv; Max12 = v.mx;
        in_valid = 1'b1;
        tries = 0;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            timeout("accept_wait");
            in_valid = 1'b0;
        end else begin
            if (push) begin
                e.q = v.q; e.sec = v.sec; e.mx = v.mx; e.dz = v.dz; e.lat = v.lat;
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (sb.size() != 0 && tries < 300) begin
            @(negedge clk);
            tries++;
        end
        if (sb.size() != 0) timeout("drain");
    endtask

    initial begin
        int tries;
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h42AC0000, 32'h40400000, 32'h40000000, 32'h437F0000, 32'h422C0000, 2'd0, 1'b0, 27));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h422C0000, 32'h42AC0000, 32'h42000000, 32'h3F000000, 2'd1, 1'b0, 27));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h42AC0000, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h41000000, 32'h3EAAAAAA, 2'd1, 1'b0, 27));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40800000, 32'h00000000, 2'd2, 1'b1, 1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000001, 32'h40A00000, 32'h00000000, 2'd2, 1'b1, 1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h00000000, 2'd3, 1'b0, 1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h40800000, 32'h41000000, 32'h40000000, 32'h437F0000, 32'h40000000, 2'd0, 1'b0, 27));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hC2AC0000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h43000000, 32'hC22C0000, 2'd2, 1'b0, 27));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h80000001, 32'h3F800000, 32'h40000000, 32'h3E000000, 32'h80000000, 2'd0, 1'b0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h3E800000, 32'hFF800000, 2'd0, 1'b0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h00800000, 32'h3F400000, 32'h7F800000, 2'd0, 1'b0, 27));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'hFF000000, 32'h3F600000, 32'h80000000, 2'd0, 1'b0, 27));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'h3FC00000, 32'h3F700000, 32'h00000000, 2'd0, 1'b0, 27));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_max_out", Max_out, 32'd0);
        chk("rst_sector_dz", {29'd0, sector, div_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) send(vecs[i], 1'b1);
        drain();

        // Backpressure: hold the result, ignore new operands, then release
        out_ready = 1'b0;
        send(vecs[0], 1'b1);
        tries = 0;
        while (!out_valid && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!out_valid) timeout("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            Max_R = 1'b0; Max_G = 1'b1; B_Rx43 = 32'h3F800000; diff = 32'h40400000;
            Max12 = 32'h12345678;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_quot", quot, 32'h422C0000);
            chk("bp_max_out", Max_out, 32'h437F0000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_out_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
        send(vecs[2], 1'b1);
        drain();

        // Reset in the middle of a division abandons it
        send(vecs[7], 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_quot", quot, 32'd0);
        chk("mid_rst_max_out", Max_out, 32'd0);
        chk("mid_rst_ctrl", {28'd0, in_ready, out_valid, sector}, 32'd0);
        chk("mid_rst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (35) @(negedge clk);
        chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);

        send(vecs[1], 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
